// File: rtl/cla_seq64_if.sv
// Requester and response bundle for the sequential 64-bit carry-lookahead adder.
// The master side issues operations and consumes results; the slave side is the adder.
interface cla_seq64_if;
   logic        req0_valid;
   logic        req0_ready;
   logic        req0_op;
   logic [63:0] req0_a;
   logic [63:0] req0_b;

   logic        req1_valid;
   logic        req1_ready;
   logic        req1_op;
   logic [63:0] req1_a;
   logic [63:0] req1_b;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [63:0] rsp_sum;
   logic        rsp_cout;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout
   );
endinterface

// File: rtl/cla_seq64.sv
// Two-requester 64-bit add/subtract unit that reuses one 16-bit carry-lookahead
// slice over four cycles, with round-robin arbitration and a held response.

// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead level.
module cla16 (
   input  logic [15:0] x_i,
   input  logic [15:0] y_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);
   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   // Bit generate/propagate, group lookahead, then per-bit carries inside each group.
   always_comb begin
      g = x_i & y_i;
      p = x_i ^ y_i;
      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      gc[0] = c_i;
      gc[1] = gg[0] | (gp[0] & c_i);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & c_i);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
      s_o = p ^ c;
      c_o = gc[4];
   end
endmodule

// state | meaning
// IDLE  | waiting for a request; ready goes to the round-robin winner
// BUSY  | one 16-bit slice per cycle, slice counter 0..3, carry chained in a register
// DONE  | result held on rsp_* until the consumer takes it
module cla_seq64 #(
   parameter int SLICES = 4
) (
   input  logic       clk,
   input  logic       reset,
   cla_seq64_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [1:0] LAST_SLICE = 2'(SLICES - 1);

   state_t      state_q, state_d;
   logic [1:0]  slice_q;
   logic        carry_q;
   logic        last_grant_q;
   logic        op_q;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic        rsp_valid_q;
   logic        rsp_id_q;
   logic [63:0] sum_q;
   logic        cout_q;

   logic        grant0, grant1, accept, last_slice;
   logic [15:0] slice_x, slice_y, slice_s;
   logic        slice_cin, slice_cout;

   // Operand slice selection; subtract inverts B and injects a carry into slice 0.
   always_comb begin
      slice_x   = a_q[{slice_q, 4'b0000} +: 16];
      slice_y   = b_q[{slice_q, 4'b0000} +: 16] ^ {16{op_q}};
      slice_cin = (slice_q == 2'd0) ? op_q : carry_q;
   end

   cla16 u_slice (
      .x_i (slice_x),
      .y_i (slice_y),
      .c_i (slice_cin),
      .s_o (slice_s),
      .c_o (slice_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and grant decode; a requester that is not last_grant wins a tie.
   always_comb begin
      state_d    = state_q;
      grant0     = 1'b0;
      grant1     = 1'b0;
      accept     = 1'b0;
      last_slice = (slice_q == LAST_SLICE);
      case (state_q)
         IDLE: begin
            if (!reset) begin
               grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
               grant0 = bus.req0_valid & ~grant1;
               accept = grant0 | grant1;
               if (accept) state_d = BUSY;
            end
         end
         BUSY:    if (last_slice) state_d = DONE;
         DONE:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture on accept, slice-by-slice accumulation, response handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         slice_q      <= 2'd0;
         carry_q      <= 1'b0;
         last_grant_q <= 1'b1;
         op_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         sum_q        <= '0;
         cout_q       <= 1'b0;
      end else begin
         if (accept) begin
            op_q         <= grant1 ? bus.req1_op : bus.req0_op;
            a_q          <= grant1 ? bus.req1_a  : bus.req0_a;
            b_q          <= grant1 ? bus.req1_b  : bus.req0_b;
            last_grant_q <= grant1;
            rsp_id_q     <= grant1;
            slice_q      <= 2'd0;
            carry_q      <= 1'b0;
         end
         if (state_q == BUSY) begin
            sum_q[{slice_q, 4'b0000} +: 16] <= slice_s;
            carry_q <= slice_cout;
            slice_q <= slice_q + 2'd1;
            if (last_slice) begin
               cout_q      <= slice_cout;
               rsp_valid_q <= 1'b1;
               slice_q     <= 2'd0;
            end
         end
         if (state_q == DONE && bus.rsp_ready) rsp_valid_q <= 1'b0;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_sum    = sum_q;
   assign bus.rsp_cout   = cout_q;
endmodule
